// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ register-file engine.
package subleq_pkg;
  localparam int ADDR_W        = 5;
  localparam int WORD_W        = 32;
  localparam int HALT_ADDR_DEF = 31;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F_AB = 3'd1,
    S_F_C  = 3'd2,
    S_OPS  = 3'd3,
    S_EXEC = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic              ena;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ datapath: mem[B] - mem[A] and the branch (result <= 0) flag.
module subleq_alu
  import subleq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] diff,
  output logic              leq0
);
  assign diff = b - a;
  assign leq0 = diff[WORD_W-1] | (diff == '0);
endmodule

// File: rtl/subleq_rf_engine.sv
// SUBLEQ engine: fetches, executes and writes back through an external 32x32 RF
// with one-cycle read latency; host preload port is live only while idle/halted.
module subleq_rf_engine
  import subleq_pkg::*;
#(
  parameter int HALT_ADDR = HALT_ADDR_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_count,
  output logic [ADDR_W-1:0] rf_ra_addr,
  output logic [ADDR_W-1:0] rf_rb_addr,
  input  logic [WORD_W-1:0] rf_ra_data,
  input  logic [WORD_W-1:0] rf_rb_data,
  output logic              rf_w_ena,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [WORD_W-1:0] rf_w_data
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] op_a, op_b, op_c, npc;
  logic              stop_req;
  logic [WORD_W-1:0] diff;
  logic              leq0;
  rf_wr_t            wr;

  subleq_alu u_alu (
    .a    (rf_ra_data),
    .b    (rf_rb_data),
    .diff (diff),
    .leq0 (leq0)
  );

  assign npc    = leq0 ? op_c : pc + ADDR_W'(3);
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  always_comb begin
    state_n    = state;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    wr         = '0;
    case (state)
      S_IDLE, S_HALT: begin
        wr = '{ena: host_we, addr: host_addr, data: host_wdata};
        if (start) state_n = S_F_AB;
      end
      S_F_AB: begin
        rf_ra_addr = pc;
        rf_rb_addr = pc + ADDR_W'(1);
        state_n    = S_F_C;
      end
      S_F_C: begin
        rf_ra_addr = pc + ADDR_W'(2);
        state_n    = S_OPS;
      end
      S_OPS: begin
        rf_ra_addr = op_a;
        rf_rb_addr = op_b;
        state_n    = S_EXEC;
      end
      S_EXEC: begin
        wr = '{ena: 1'b1, addr: op_b, data: diff};
        if (npc == ADDR_W'(HALT_ADDR)) state_n = S_HALT;
        else if (stop || stop_req)     state_n = S_IDLE;
        else                           state_n = S_F_AB;
      end
      default: state_n = S_IDLE;
    endcase
    // Reset kills the write port outright, including an EXEC write in flight.
    if (rst) wr = '0;
  end

  assign rf_w_ena  = wr.ena;
  assign rf_w_addr = wr.addr;
  assign rf_w_data = wr.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      instr_count <= '0;
      stop_req    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= start_pc;
            instr_count <= '0;
            stop_req    <= 1'b0;
          end
        end
        S_F_AB: if (stop) stop_req <= 1'b1;
        S_F_C: begin
          op_a <= rf_ra_data[ADDR_W-1:0];
          op_b <= rf_rb_data[ADDR_W-1:0];
          if (stop) stop_req <= 1'b1;
        end
        S_OPS: begin
          op_c <= rf_ra_data[ADDR_W-1:0];
          if (stop) stop_req <= 1'b1;
        end
        S_EXEC: begin
          pc       <= npc;
          stop_req <= 1'b0;
          if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subleq_rf_engine.sv
// Bench: RF model beside the engine, directed scenarios plus random programs
// checked against a plain SUBLEQ interpreter.
module tb_subleq_rf_engine;
  logic        clk = 1'b0;
  logic        rst, start, stop, host_we;
  logic [4:0]  start_pc, host_addr;
  logic [31:0] host_wdata;
  logic        busy, halted;
  logic [4:0]  pc, rf_ra_addr, rf_rb_addr, rf_w_addr;
  logic [3:0]  instr_count;
  logic [31:0] rf_ra_data, rf_rb_data, rf_w_data;
  logic        rf_w_ena;

  logic [31:0] rf_mem  [32];
  logic [31:0] ref_mem [32];
  logic [31:0] img     [32];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  subleq_rf_engine #(.HALT_ADDR(31), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .stop(stop),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .busy(busy), .halted(halted), .pc(pc), .instr_count(instr_count),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .rf_w_ena(rf_w_ena), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
  );

  // Register file: registered reads with same-cycle write forwarding.
  always @(posedge clk) begin
    if (rf_w_ena) rf_mem[rf_w_addr] <= rf_w_data;
    rf_ra_data <= (rf_w_ena && rf_w_addr == rf_ra_addr) ? rf_w_data : rf_mem[rf_ra_addr];
    rf_rb_data <= (rf_w_ena && rf_w_addr == rf_rb_addr) ? rf_w_data : rf_mem[rf_rb_addr];
  end

  // Reference SUBLEQ interpreter: runs up to n instructions or until halt.
  task automatic model_run(input logic [4:0] p0, input int n,
                           output logic [4:0] pe, output int ce, output logic he);
    logic [4:0]  p, a, b, c;
    logic [31:0] d;
    p = p0; ce = 0; he = 1'b0;
    for (int i = 0; i < n && !he; i++) begin
      a = ref_mem[p][4:0];
      b = ref_mem[5'(p + 1)][4:0];
      c = ref_mem[5'(p + 2)][4:0];
      d = ref_mem[b] - ref_mem[a];
      ref_mem[b] = d;
      p = ($signed(d) <= 0) ? c : 5'(p + 3);
      if (ce < 15) ce++;
      if (p == 5'd31) he = 1'b1;
    end
    pe = p;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 32'h0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      host_we = 1'b1; host_addr = 5'(i); host_wdata = img[i];
      ref_mem[i] = img[i];
    end
    @(negedge clk);
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  // Leaves the bench at the first negedge after the start edge (F_AB cycle).
  task automatic start_run(input logic [4:0] p);
    @(negedge clk);
    start = 1'b1; start_pc = p;
    @(negedge clk);
    start = 1'b0; start_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; start_pc = 0;
    host_we = 1'b1; host_addr = 5'd7; host_wdata = 32'h1234;
    repeat (2) @(negedge clk);
    total++; if (rf_w_ena !== 1'b0) begin bad++; $display("FAIL rst_wena: got %b want 0", rf_w_ena); end
    host_we = 0; host_addr = 0; host_wdata = 0;
    #1;
    total++; if ({busy, halted} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {busy, halted}); end
    total++; if (pc !== 5'd0 || instr_count !== 4'd0) begin bad++; $display("FAIL rst_pc_cnt: got %0d/%0d want 0/0", pc, instr_count); end
    total++; if ({rf_ra_addr, rf_rb_addr, rf_w_ena, rf_w_addr, rf_w_data} !== '0)
      begin bad++; $display("FAIL rst_rf: got ra=%0d rb=%0d we=%b wa=%0d wd=%0h want all 0", rf_ra_addr, rf_rb_addr, rf_w_ena, rf_w_addr, rf_w_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_instr();
    logic [4:0] ep; int ec; logic eh;
    clear_img();
    img[0] = 10; img[1] = 11; img[2] = 3; img[3] = 11; img[4] = 11; img[5] = 31;
    img[10] = 5; img[11] = 7;
    load_img();
    model_run(5'd0, 10, ep, ec, eh);
    start_run(5'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy: got %b want 1", busy); end
    repeat (3) @(negedge clk);
    total++; if ({rf_w_ena, rf_w_addr, rf_w_data} !== {1'b1, 5'd11, 32'd2})
      begin bad++; $display("FAIL first_write: got we=%b wa=%0d wd=%0h want 1/11/2", rf_w_ena, rf_w_addr, rf_w_data); end
    @(negedge clk);
    total++; if (pc !== 5'd3 || instr_count !== 4'd1) begin bad++; $display("FAIL first_pc_cnt: got %0d/%0d want 3/1", pc, instr_count); end
    repeat (3) @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL early_halt: got %b want 0", halted); end
    @(negedge clk);
    total++; if ({halted, busy} !== 2'b10 || pc !== ep || instr_count !== 4'(ec))
      begin bad++; $display("FAIL halt_state: got h=%b b=%b pc=%0d cnt=%0d want 1/0/%0d/%0d", halted, busy, pc, instr_count, ep, ec); end
    total++; if (rf_mem[11] !== 32'd0) begin bad++; $display("FAIL halt_mem11: got %0h want 0", rf_mem[11]); end
    repeat (3) @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_hold: got %b want 1", halted); end
  endtask

  task automatic test_negative();
    clear_img();
    img[0] = 20; img[1] = 21; img[2] = 7; img[20] = 1; img[21] = 0;
    img[7] = 22; img[8] = 22; img[9] = 31;
    load_img();
    start_run(5'd0);
    repeat (3) @(negedge clk);
    total++; if ({rf_w_ena, rf_w_addr, rf_w_data} !== {1'b1, 5'd21, 32'hFFFF_FFFF})
      begin bad++; $display("FAIL neg_write: got we=%b wa=%0d wd=%0h want 1/21/ffffffff", rf_w_ena, rf_w_addr, rf_w_data); end
    @(negedge clk);
    total++; if (pc !== 5'd7) begin bad++; $display("FAIL neg_branch: got %0d want 7", pc); end
    repeat (4) @(negedge clk);
    total++; if (halted !== 1'b1 || rf_mem[21] !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL neg_final: got h=%b m21=%0h want 1/ffffffff", halted, rf_mem[21]); end
  endtask

  task automatic test_wrap();
    clear_img();
    img[30] = 12; img[31] = 13; img[0] = 9; img[12] = 2; img[13] = 5;
    img[1] = 14; img[2] = 14; img[3] = 31;
    load_img();
    start_run(5'd30);
    total++; if (rf_ra_addr !== 5'd30 || rf_rb_addr !== 5'd31)
      begin bad++; $display("FAIL wrap_fab: got %0d/%0d want 30/31", rf_ra_addr, rf_rb_addr); end
    @(negedge clk);
    total++; if (rf_ra_addr !== 5'd0) begin bad++; $display("FAIL wrap_fc: got %0d want 0", rf_ra_addr); end
    @(negedge clk);
    total++; if (rf_ra_addr !== 5'd12 || rf_rb_addr !== 5'd13)
      begin bad++; $display("FAIL wrap_ops: got %0d/%0d want 12/13", rf_ra_addr, rf_rb_addr); end
    @(negedge clk);
    total++; if ({rf_w_ena, rf_w_addr, rf_w_data} !== {1'b1, 5'd13, 32'd3})
      begin bad++; $display("FAIL wrap_write: got we=%b wa=%0d wd=%0h want 1/13/3", rf_w_ena, rf_w_addr, rf_w_data); end
    @(negedge clk);
    total++; if (pc !== 5'd1) begin bad++; $display("FAIL wrap_npc: got %0d want 1", pc); end
    repeat (4) @(negedge clk);
    total++; if (halted !== 1'b1 || pc !== 5'd31) begin bad++; $display("FAIL wrap_halt: got h=%b pc=%0d want 1/31", halted, pc); end
  endtask

  task automatic test_stop();
    clear_img();
    img[0] = 16; img[1] = 17; img[2] = 0; img[5] = 32'h55;
    load_img();
    start_run(5'd0);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    host_we = 1'b1; host_addr = 5'd5; host_wdata = 32'hAAAA;
    #1;
    total++; if ({rf_w_ena, rf_w_addr, rf_w_data} !== {1'b1, 5'd17, 32'd0})
      begin bad++; $display("FAIL stop_write: got we=%b wa=%0d wd=%0h want 1/17/0", rf_w_ena, rf_w_addr, rf_w_data); end
    @(negedge clk);
    host_addr = 5'd6; host_wdata = 32'hBBBB;
    total++; if ({busy, halted} !== 2'b00 || pc !== 5'd0 || instr_count !== 4'd1)
      begin bad++; $display("FAIL stop_idle: got b=%b h=%b pc=%0d cnt=%0d want 0/0/0/1", busy, halted, pc, instr_count); end
    @(negedge clk);
    host_we = 1'b0; host_addr = 0; host_wdata = 0;
    total++; if (rf_mem[5] !== 32'h55) begin bad++; $display("FAIL stop_host_ignored: got %0h want 55", rf_mem[5]); end
    total++; if (rf_mem[6] !== 32'hBBBB) begin bad++; $display("FAIL stop_host_applied: got %0h want bbbb", rf_mem[6]); end
  endtask

  task automatic test_rst_exec();
    clear_img();
    img[0] = 16; img[1] = 17; img[2] = 0; img[16] = 1; img[17] = 5;
    load_img();
    start_run(5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (rf_w_ena !== 1'b0) begin bad++; $display("FAIL rstx_wena: got %b want 0", rf_w_ena); end
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy, halted} !== 2'b00 || pc !== 5'd0 || instr_count !== 4'd0)
      begin bad++; $display("FAIL rstx_state: got b=%b h=%b pc=%0d cnt=%0d want 0/0/0/0", busy, halted, pc, instr_count); end
    total++; if ({rf_ra_addr, rf_rb_addr, rf_w_ena, rf_w_addr, rf_w_data} !== '0)
      begin bad++; $display("FAIL rstx_rf: got ra=%0d rb=%0d we=%b wa=%0d wd=%0h want all 0", rf_ra_addr, rf_rb_addr, rf_w_ena, rf_w_addr, rf_w_data); end
    total++; if (rf_mem[17] !== 32'd5) begin bad++; $display("FAIL rstx_mem: got %0h want 5", rf_mem[17]); end
  endtask

  // Runs n instructions (stop raised during the n-th), or until halt, then compares.
  task automatic run_and_check(input string tag, input logic [4:0] p0, input int n);
    logic [4:0] ep; int ec; logic eh; int nbad;
    model_run(p0, n, ep, ec, eh);
    start_run(p0);
    repeat (4 * n - 2) @(negedge clk);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    total++; if (halted !== eh || busy !== 1'b0 || pc !== ep || instr_count !== 4'(ec))
      begin bad++; $display("FAIL %s_state: got h=%b b=%b pc=%0d cnt=%0d want %b/0/%0d/%0d", tag, halted, busy, pc, instr_count, eh, ep, ec); end
    nbad = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[i] !== ref_mem[i]) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL %s_mem: got %0d differing words want 0", tag, nbad); end
  endtask

  task automatic test_saturate();
    clear_img();
    img[0] = 16; img[1] = 17; img[2] = 0;
    load_img();
    run_and_check("sat", 5'd0, 20);
    total++; if (instr_count !== 4'hF) begin bad++; $display("FAIL sat_cnt: got %0d want 15", instr_count); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load_img();
      run_and_check("rand", 5'($urandom_range(0, 31)), $urandom_range(1, 30));
    end
  endtask

  initial begin
    test_reset();
    test_first_instr();
    test_negative();
    test_wrap();
    test_stop();
    test_rst_exec();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
